// File: rtl/shared_pkg.sv
// Shared FIFO geometry and arbiter state type for the FIFO write-arbiter slice.
package shared_pkg;

    localparam int unsigned FIFO_WIDTH = 16;
    localparam int unsigned FIFO_DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after rr_ptr, scanning upward with wrap.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   idx
);

    logic             found;
    logic [PTR_W-1:0] pos;

    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[pos]) begin
                found       = 1'b1;
                winner[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter funnelling NUM_REQ writers into one FIFO write port.
module fifo_wr_arbiter
    import shared_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          full,
    input  logic                          almostfull,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    arb_state_e       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] acc_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [CNT_W-1:0] beat_cnt;
    logic             block;
    logic             accept;
    logic             last_beat;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
        return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (pick_gnt),
        .idx    (pick_idx)
    );

    // almostfull alone is not enough: the write registered last cycle is not yet in the flags
    assign block     = full | (almostfull & wr_en);
    assign accept    = |(gnt & req);
    assign acc_idx   = (state == IDLE) ? pick_idx : owner;
    assign last_beat = (32'(beat_cnt) + 1 == BURST_LEN);
    assign busy      = (state == BURST);

    always_comb begin
        gnt = '0;
        if (rst_n && !block) begin
            if (state == IDLE) begin
                gnt = pick_gnt;
            end else if (req[owner]) begin
                gnt[owner] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            wr_en    <= 1'b0;
            data_in  <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                data_in <= req_data[32'(acc_idx) * FIFO_WIDTH +: FIFO_WIDTH];
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner    <= pick_idx;
                        beat_cnt <= CNT_W'(1);
                        if (BURST_LEN > 1) begin
                            state <= BURST;
                        end else begin
                            rr_ptr <= wrap_inc(pick_idx);
                        end
                    end
                end
                BURST: begin
                    if (!req[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= wrap_inc(owner);
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= wrap_inc(owner);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural arbiter/FIFO model.
module tb_fifo_wr_arbiter;
    import shared_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned BL = 4;
    localparam int unsigned W  = FIFO_WIDTH;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0]   gnt;
    logic            wr_en;
    logic [W-1:0]    data_in;
    logic            full;
    logic            almostfull;
    logic [1:0]      owner;
    logic            busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .BURST_LEN (BL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .full       (full),
        .almostfull (almostfull),
        .owner      (owner),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model of the arbiter and the FIFO it feeds
    bit          m_burst;
    int          m_ptr;
    int          m_owner;
    int          m_cnt;
    bit          m_wr;
    logic [W-1:0] m_data;
    logic [NR-1:0] m_last_acc;
    bit          use_fifo = 1'b0;
    int          fifo_cnt;
    int          wait_beats [NR];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_burst    = 1'b0;
        m_ptr      = 0;
        m_owner    = 0;
        m_cnt      = 0;
        m_wr       = 1'b0;
        m_data     = '0;
        m_last_acc = '0;
        fifo_cnt   = 0;
        for (int i = 0; i < NR; i++) wait_beats[i] = 0;
    endtask

    function automatic logic [NR-1:0] model_gnt();
        logic [NR-1:0] g = '0;
        if (full || (almostfull && m_wr)) return g;
        if (!m_burst) begin
            for (int k = 0; k < NR; k++) begin
                int i = (m_ptr + k) % NR;
                if (req[i]) begin
                    g[i] = 1'b1;
                    return g;
                end
            end
            return g;
        end
        if (req[m_owner]) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic int idx_of(input logic [NR-1:0] g);
        for (int i = 0; i < NR; i++) if (g[i]) return i;
        return 0;
    endfunction

    // one clock: check gnt now, step the model across the edge, check registered outputs
    task automatic tick();
        logic [NR-1:0]   g;
        logic [NR-1:0]   req_s;
        logic [NR*W-1:0] data_s;
        bit              acc;
        bit              wr_s;
        int              w;
        int              rd;
        #1;
        g      = model_gnt();
        acc    = (g != '0);
        w      = idx_of(g);
        req_s  = req;
        data_s = req_data;
        chk("gnt", 32'(gnt), 32'(g));
        wr_s = wr_en;
        rd   = 0;
        if (use_fifo) begin
            chk("fifo_overflow", {31'b0, (wr_en && fifo_cnt >= int'(FIFO_DEPTH))}, 32'd0);
            rd = (fifo_cnt > 0 && $urandom_range(0, 1) == 1) ? 1 : 0;
            for (int i = 0; i < NR; i++) begin
                if (!req_s[i]) begin
                    wait_beats[i] = 0;
                end else if (g[i]) begin
                    chk("starvation", {31'b0, (wait_beats[i] <= int'(NR * BL))}, 32'd1);
                    wait_beats[i] = 0;
                end else if (acc) begin
                    wait_beats[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
        m_wr = acc;
        if (acc) m_data = data_s[w*W +: W];
        if (!m_burst) begin
            if (acc) begin
                m_owner = w;
                m_cnt   = 1;
                if (BL > 1) m_burst = 1'b1;
                else        m_ptr   = (w + 1) % NR;
            end
        end else if (!req_s[m_owner]) begin
            m_burst = 1'b0;
            m_ptr   = (m_owner + 1) % NR;
        end else if (acc) begin
            m_cnt++;
            if (m_cnt == BL) begin
                m_burst = 1'b0;
                m_ptr   = (m_owner + 1) % NR;
            end
        end
        m_last_acc = g;
        if (use_fifo) begin
            fifo_cnt   = fifo_cnt + int'(wr_s) - rd;
            full       = (fifo_cnt == int'(FIFO_DEPTH));
            almostfull = (fifo_cnt >= int'(FIFO_DEPTH) - 1);
        end
        chk("wr_en", {31'b0, wr_en}, {31'b0, m_wr});
        chk("data_in", 32'(data_in), 32'(m_data));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("busy", {31'b0, busy}, {31'b0, m_burst});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req        = '0;
        full       = 1'b0;
        almostfull = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [W-1:0] order [16];
    int           nw;

    initial begin
        rst_n      = 1'b0;
        req        = '1;
        req_data   = '1;
        full       = 1'b0;
        almostfull = 1'b0;
        model_reset();
        #12;
        chk("reset_wr_en", {31'b0, wr_en}, 32'd0);
        chk("reset_data_in", 32'(data_in), 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_owner", 32'(owner), 32'd0);
        chk("reset_gnt", 32'(gnt), 32'd0);

        // single requester, empty FIFO
        do_reset();
        req_data          = '0;
        req_data[0 +: W]  = 16'hA5A5;
        req               = 4'b0001;
        #1;
        chk("t030_gnt", 32'(gnt), 32'h1);
        tick();
        chk("t030_wr_en", {31'b0, wr_en}, 32'd1);
        chk("t030_data", 32'(data_in), 32'hA5A5);
        chk("t030_busy", {31'b0, busy}, 32'd1);
        req = '0;
        tick();

        // all requesting: four bursts of four in index order, pointer wraps to 0
        do_reset();
        for (int i = 0; i < NR; i++) req_data[i*W +: W] = 16'(i);
        req = 4'b1111;
        nw  = 0;
        for (int t = 0; t < 40 && nw < 16; t++) begin
            tick();
            if (wr_en) begin
                order[nw] = data_in;
                nw++;
            end
        end
        chk("t031_count", 32'(nw), 32'd16);
        for (int k = 0; k < 16; k++) chk("t031_order", 32'(order[k]), 32'(k / 4));
        chk("t031_busy", {31'b0, busy}, 32'd0);
        #1;
        chk("t031_wrap_gnt", 32'(gnt), 32'h1);

        // owner 2 stalled by full for three cycles mid-burst
        do_reset();
        req_data = '0;
        req_data[2*W +: W] = 16'h00C2;
        req = 4'b0100;
        tick();
        tick();
        full = 1'b1;
        for (int t = 0; t < 3; t++) begin
            #1;
            chk("t032_gnt", 32'(gnt), 32'd0);
            tick();
            chk("t032_wr_en", {31'b0, wr_en}, 32'd0);
            chk("t032_owner", 32'(owner), 32'd2);
            chk("t032_busy", {31'b0, busy}, 32'd1);
        end
        full = 1'b0;
        tick();
        chk("t032_resume_wr", {31'b0, wr_en}, 32'd1);
        chk("t032_resume_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("t032_last_wr", {31'b0, wr_en}, 32'd1);
        chk("t032_end_busy", {31'b0, busy}, 32'd0);

        // almostfull together with a write in flight blocks; alone it does not
        do_reset();
        req_data = '0;
        req = 4'b0001;
        tick();
        almostfull = 1'b1;
        #1;
        chk("t033_gnt_block", 32'(gnt), 32'd0);
        tick();
        chk("t033_wr_en", {31'b0, wr_en}, 32'd0);
        #1;
        chk("t033_gnt_free", 32'(gnt), 32'h1);
        tick();
        almostfull = 1'b0;
        req = '0;
        tick();

        // owner 1 drops after two beats; requester 3 wins next
        do_reset();
        req_data = '0;
        req = 4'b0010;
        tick();
        tick();
        req = 4'b1000;
        #1;
        chk("t034_drop_gnt", 32'(gnt), 32'd0);
        tick();
        chk("t034_idle", {31'b0, busy}, 32'd0);
        #1;
        chk("t034_gnt3", 32'(gnt), 32'h8);
        tick();
        chk("t034_owner", 32'(owner), 32'd3);

        // asynchronous reset mid-burst
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t035_wr_en", {31'b0, wr_en}, 32'd0);
        chk("t035_gnt", 32'(gnt), 32'd0);
        chk("t035_busy", {31'b0, busy}, 32'd0);
        model_reset();
        req = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t035_first", 32'(gnt), 32'h2);
        tick();

        // random traffic against the model with a draining FIFO
        do_reset();
        use_fifo = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < NR; i++) begin
                if (m_last_acc[i]) begin
                    req[i] = ($urandom_range(0, 3) != 0);
                    req_data[i*W +: W] = 16'($urandom);
                end else if (req[i]) begin
                    if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    req[i] = 1'b1;
                    req_data[i*W +: W] = 16'($urandom);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
